// File: rtl/present80_pkg.sv
// PRESENT-80 shared definitions: widths, round count, FSM states,
// S-box table and the bit-permutation layer.
package present80_pkg;

  localparam int KEY_W      = 80;
  localparam int BLK_W      = 64;
  localparam int ROUNDS_DEF = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Bit i lands on (16*i) mod 63; bit 63 is fixed.
  function automatic logic [BLK_W-1:0] p_layer(
    input logic [BLK_W-1:0] d
  );
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) begin
      o[(16 * i) % 63] = d[i];
    end
    o[63] = d[63];
    return o;
  endfunction

endpackage

// File: rtl/present80_sbox.sv
// PRESENT 4-bit S-box, purely combinational.
// Ports: x_i 4-bit input nibble, y_o 4-bit substituted nibble.
module present80_sbox
  import present80_pkg::*;
(
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);

  assign y_o = SBOX[x_i];

endmodule

// File: rtl/present80_round_ctrl.sv
// Round-iterative PRESENT-80 encryptor: one round per clock, then
// key whitening. Ports: wb_clk_i, wb_rst_i (async, active-high),
// start, key_i[79:0], plain_i[63:0], abort_i (only with
// PRESENT80_ABORT_EN), cipher_o[63:0], busy_o, done_o.
module present80_round_ctrl
  import present80_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
`ifdef PRESENT80_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic [KEY_W-1:0] key_i,
  input  logic [BLK_W-1:0] plain_i,
  output logic [BLK_W-1:0] cipher_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [4:0] LAST = 5'(ROUNDS);

  state_e           fsm_q, fsm_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] cipher_q, cipher_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BLK_W-1:0] mix;
  logic [BLK_W-1:0] sub;
  logic [KEY_W-1:0] key_rot;
  logic [3:0]       key_sb;
  logic [KEY_W-1:0] key_nxt;

  // Round-key addition; also the final whitening value.
  assign mix = state_q ^ key_q[79:16];

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    present80_sbox u_sb (
      .x_i (mix[4*g +: 4]),
      .y_o (sub[4*g +: 4])
    );
  end

  // Rotate left by 61 == rotate right by 19.
  assign key_rot = {key_q[18:0], key_q[79:19]};

  present80_sbox u_ks (
    .x_i (key_rot[79:76]),
    .y_o (key_sb)
  );

  assign key_nxt = {key_sb,
                    key_rot[75:20],
                    key_rot[19:15] ^ rnd_q,
                    key_rot[14:0]};

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    key_d    = key_q;
    rnd_d    = rnd_q;
    cipher_d = cipher_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d   = ROUND;
          state_d = plain_i;
          key_d   = key_i;
          rnd_d   = 5'd1;
          busy_d  = 1'b1;
        end
      end
      ROUND: begin
        state_d = p_layer(sub);
        key_d   = key_nxt;
        // Counter holds at the last round rather than wrapping.
        if (rnd_q == LAST) begin
          fsm_d = FINAL;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      FINAL: begin
        cipher_d = mix;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        fsm_d    = IDLE;
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
`ifdef PRESENT80_ABORT_EN
    // Abort beats completion, even in the FINAL cycle.
    if (abort_i && (fsm_q != IDLE)) begin
      fsm_d    = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cipher_d = cipher_q;
    end
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      rnd_q    <= '0;
      cipher_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      key_q    <= key_d;
      rnd_q    <= rnd_d;
      cipher_q <= cipher_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cipher_o = cipher_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_present80_round_ctrl.sv
// Self-checking bench for present80_round_ctrl: known vectors,
// random blocks against a reference cipher, control corner cases.
module tb_present80_round_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start    = 1'b0;
`ifdef PRESENT80_ABORT_EN
  logic        abort_i  = 1'b0;
`endif
  logic [79:0] key_i    = '0;
  logic [63:0] plain_i  = '0;
  logic [63:0] cipher_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13,
                  3, 14, 15, 8, 4, 7, 1, 2};

  present80_round_ctrl dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .start    (start),
`ifdef PRESENT80_ABORT_EN
    .abort_i  (abort_i),
`endif
    .key_i    (key_i),
    .plain_i  (plain_i),
    .cipher_o (cipher_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [63:0] ref_enc(
    input logic [79:0] k,
    input logic [63:0] p
  );
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    int          dst;
    s  = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) begin
        t[4*n +: 4] = 4'(SB[s[4*n +: 4]]);
      end
      for (int i = 0; i < 64; i++) begin
        dst = (i == 63) ? 63 : (i * 16) % 63;
        s[dst] = t[i];
      end
      kk = (kk << 61) | (kk >> 19);
      kk[79:76] = 4'(SB[kk[79:76]]);
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch, wait for done (bounded), check latency and result.
  // chg >= 0 scrambles key_i/plain_i just before edge N+chg.
  task automatic run(input string tag,
                     input logic [79:0] k,
                     input logic [63:0] p,
                     input int chg);
    int n;
    key_i   = k;
    plain_i = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk({tag, "_busy0"}, 80'(busy_o), 80'd1);
    chk({tag, "_done0"}, 80'(done_o), 80'd0);
    n = 0;
    while (!done_o && n < 40) begin
      if (n + 1 == chg) begin
        key_i   = {$urandom, $urandom, 16'($urandom)};
        plain_i = {$urandom, $urandom};
      end
      tick();
      n++;
    end
    chk({tag, "_lat"}, 80'(n), 80'd32);
    chk({tag, "_ct"}, 80'(cipher_o), 80'(ref_enc(k, p)));
    chk({tag, "_busyF"}, 80'(busy_o), 80'd0);
  endtask

  initial begin
    logic [79:0] rk;
    logic [63:0] rp;
    logic [63:0] prev;
    int          dn;
    int          falls;
    int          dat;
    logic        pb;

    tick();
    tick();
    chk("rst_ct", 80'(cipher_o), 80'd0);
    chk("rst_busy", 80'(busy_o), 80'd0);
    chk("rst_done", 80'(done_o), 80'd0);
    wb_rst_i = 1'b0;
    tick();
    chk("idle_busy", 80'(busy_o), 80'd0);

    run("kv0", 80'h0, 64'h0, -1);
    chk("kv0_const", 80'(cipher_o), 80'h5579C1387B228445);
    tick();
    chk("kv0_doneclr", 80'(done_o), 80'd0);
    chk("kv0_hold", 80'(cipher_o), 80'h5579C1387B228445);

    run("kv1", {80{1'b1}}, 64'h0, -1);
    chk("kv1_const", 80'(cipher_o), 80'hE72C46C0F5945049);
    // Back-to-back: launch on the edge right after done.
    run("kv2", {80{1'b1}}, {64{1'b1}}, -1);
    chk("kv2_const", 80'(cipher_o), 80'h3333DCD3213210D2);
    tick();

    run("kv3", 80'h0, {64{1'b1}}, 5);
    chk("kv3_const", 80'(cipher_o), 80'hA112FFC72F68417B);
    tick();

    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, 16'($urandom)};
      rp = {$urandom, $urandom};
      run("rnd", rk, rp, -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Start re-pulsed while busy must be ignored.
    rk = {$urandom, $urandom, 16'($urandom)};
    rp = {$urandom, $urandom};
    key_i   = rk;
    plain_i = rp;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    dn    = 0;
    falls = 0;
    dat   = -1;
    pb    = busy_o;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 10 || c == 32);
      tick();
      start = 1'b0;
      if (done_o) begin
        dn++;
        dat = c;
      end
      if (pb && !busy_o) falls++;
      pb = busy_o;
    end
    chk("rep_dones", 80'(dn), 80'd1);
    chk("rep_falls", 80'(falls), 80'd1);
    chk("rep_when", 80'(dat), 80'd32);
    chk("rep_ct", 80'(cipher_o), 80'(ref_enc(rk, rp)));

    // Asynchronous reset mid-round.
    key_i   = 80'h1234;
    plain_i = 64'h5678;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (10) tick();
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("arst_ct", 80'(cipher_o), 80'd0);
    chk("arst_busy", 80'(busy_o), 80'd0);
    chk("arst_done", 80'(done_o), 80'd0);
    tick();
    wb_rst_i = 1'b0;
    repeat (3) tick();
    chk("arst_idle", 80'(busy_o), 80'd0);
    run("post_rst", 80'h0, 64'h0, -1);
    chk("post_rst_c", 80'(cipher_o), 80'h5579C1387B228445);
    tick();

`ifdef PRESENT80_ABORT_EN
    prev    = cipher_o;
    key_i   = {80{1'b1}};
    plain_i = 64'h0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (14) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_busy", 80'(busy_o), 80'd0);
    chk("ab_ct", 80'(cipher_o), 80'(prev));
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done_o) dn++;
    end
    chk("ab_nodone", 80'(dn), 80'd0);
    chk("ab_ct2", 80'(cipher_o), 80'(prev));
    run("ab_next", {80{1'b1}}, 64'h0, -1);
    chk("ab_next_c", 80'(cipher_o), 80'hE72C46C0F5945049);
`else
    prev = cipher_o;
    chk("noab_hold", 80'(prev), 80'h5579C1387B228445);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
